ram_rr_arbiter: RTL and testbench
=================================

Name: ram_rr_arbiter

Overview:
Round-robin arbiter that shares the single RAM port between REQS cache-side requesters (default: icache0, dcache0, icache1, dcache1).
- Grants one requester at a time and holds the grant across multi-beat transfers.
- Enforces a per-grant access cap so no requester can starve the others.
- Sits between the cache/coherence logic and the RAM model. It replaces fixed-priority RAM selection; coherence logic is not involved.

Parameters:
REQS, 4, number of requesters (>=2)
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_BEATS, 8, ACCESS beats per grant before a forced release when others are pending (>=1)

Ports:
CLK  in  1  clock; all state updates on rising edge
nRST  in  1  reset, synchronous, active-low
req_ren  in  REQS  per-requester read request
req_wen  in  REQS  per-requester write request
req_addr  in  REQS*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_store  in  REQS*DATA_W  flattened write data, same packing
req_load  out  DATA_W  read data, broadcast to all requesters
req_wait  out  REQS  per-requester wait (1 = stall)
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramload  in  DATA_W  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
grant_valid  out  1  a grant is active
grant_id  out  $clog2(REQS)  index of the granted requester

Behaviour:
- Reset (nRST low at a rising edge):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - Consequently grant_valid=0, ramREN=ramWEN=0, ramaddr=ramstore=0, req_load=0, req_wait all 1.
- Active request: req_act[i] = req_ren[i] | req_wen[i].
- FSM states: IDLE and GRANT.
- IDLE:
  - No RAM access; all outputs at reset values.
  - If any req_act is set, pick the first active index scanning rr_ptr, rr_ptr+1, ... modulo REQS.
  - Register the winner into grant_id, clear beat_cnt, go to GRANT. Arbitration latency is exactly 1 cycle.
  - If no request, stay in IDLE.
- GRANT (g = grant_id):
  - grant_valid=1; ramaddr and ramstore come from requester g.
  - req_wen[g]=1: ramWEN=1, ramREN=0. Write wins when both are set.
  - Otherwise: ramREN=req_ren[g], ramWEN=0.
  - req_load=ramload.
  - req_wait[g] = (ramstate!=ACCESS); every other req_wait bit=1.
  - On each cycle with ramstate==ACCESS and req_act[g]: beat_cnt increments, saturating at MAX_BEATS.
- GRANT exit conditions, evaluated each cycle; on exit go to IDLE and set rr_ptr = (g+1) mod REQS:
  - (a) req_act[g]==0.
  - (b) Forced release: the cycle is an ACCESS beat, beat_cnt+1 >= MAX_BEATS, and some other req_act[j] is set. The beat in that cycle completes normally.
- Without contention, the grant holds indefinitely and beat_cnt saturates.
- ramstate ERROR, BUSY or FREE while in GRANT: all waits stay 1 and the grant is held. Exit condition (a) still applies.
- The requester at grant_id is ignored in IDLE only through rr_ptr rotation; no other masking.
- Reset mid-GRANT: the next edge returns to IDLE and the RAM enables drop that cycle. An in-flight RAM access is abandoned with no completion signalled.
- All datapath outputs are combinational from registered state and the inputs.

Test Plan:
1. Requester 1 reads addr 0x100; ramstate BUSY,BUSY,ACCESS with ramload=0xDEADBEEF.
   -> grant_id=1 one cycle after request; ramREN=1, ramaddr=0x100.
   -> req_wait[1]=0 only in the ACCESS cycle, req_load=0xDEADBEEF; waits 0,2,3 stay 1.
2. All four requesters assert together after reset and each drops after one ACCESS beat.
   -> grant order 0,1,2,3, each separated by one IDLE cycle.
3. MAX_BEATS=4; requester 2 streams with ramstate always ACCESS; requester 0 asserts at beat 1.
   -> release after beat 4; grant_id=0 two cycles later; rr_ptr=3.
4. Requester 3 holds alone for 20 beats.
   -> no forced release; grant_valid stays 1.
5. Requester 0 with ren=wen=1, store=0x55AA.
   -> ramWEN=1, ramREN=0, ramstore=0x55AA.
6. nRST low mid-GRANT, and ramstate=ERROR during a grant.
   -> after reset edge: grant_valid=0, ram enables 0, waits all 1.
   -> under ERROR: all waits held at 1 and grant_id unchanged.

Source files
------------

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: shares one RAM port between REQS cache-side requesters.
// A round-robin pointer picks the next requester while IDLE. The grant is
// held across multi-beat transfers. It is released when the owner stops
// requesting, or when the owner has used MAX_BEATS ACCESS beats while
// another requester is waiting.
//
// Handshake: a requester holds req_ren/req_wen (with address/data) stable
// until it sees req_wait low. A low req_wait means this cycle's RAM beat
// completes. req_wait is low only for the granted requester, and only in
// a cycle where ramstate reports ACCESS.
module ram_rr_arbiter #(
  parameter int REQS      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 8
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [REQS-1:0]           req_ren,
  input  logic [REQS-1:0]           req_wen,
  input  logic [REQS*ADDR_W-1:0]    req_addr,
  input  logic [REQS*DATA_W-1:0]    req_store,
  output logic [DATA_W-1:0]         req_load,
  output logic [REQS-1:0]           req_wait,
  output logic [ADDR_W-1:0]         ramaddr,
  output logic [DATA_W-1:0]         ramstore,
  output logic                      ramREN,
  output logic                      ramWEN,
  input  logic [DATA_W-1:0]         ramload,
  input  logic [1:0]                ramstate,
  output logic                      grant_valid,
  output logic [$clog2(REQS)-1:0]   grant_id
);

  localparam int ID_W  = $clog2(REQS);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  localparam logic [1:0]       RS_ACCESS = 2'd2;
  localparam logic [ID_W:0]    REQS_EXT  = (ID_W+1)'(REQS);
  localparam logic [CNT_W:0]   MAX_EXT   = (CNT_W+1)'(MAX_BEATS);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_BEATS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e           state_q,    state_d;
  logic [ID_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [REQS-1:0]   req_act;
  logic [2*REQS-1:0] act_dbl;
  logic [REQS-1:0]   act_rot;
  logic [ID_W-1:0]   pick_off;
  logic [ID_W:0]     pick_sum;
  logic              pick_found;
  logic [ID_W-1:0]   win_id;

  logic              in_grant;
  logic              act_g;
  logic              others_act;
  logic              access_beat;
  logic [CNT_W:0]    beat_next;
  logic              cap_hit;
  logic              force_rel;
  logic [ID_W:0]     ptr_sum;
  logic [ID_W-1:0]   ptr_after;

  // Round-robin pick: rotate the active vector so rr_ptr sits at bit 0,
  // take the lowest set bit, then map the offset back to an index.
  always_comb begin
    req_act    = req_ren | req_wen;
    act_dbl    = {req_act, req_act} >> rr_ptr_q;
    act_rot    = act_dbl[REQS-1:0];
    pick_found = |act_rot;
    pick_off   = '0;
    for (int k = REQS - 1; k >= 0; k--) begin
      if (act_rot[k]) begin
        pick_off = ID_W'(k);
      end
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    if (pick_sum >= REQS_EXT) begin
      pick_sum = pick_sum - REQS_EXT;
    end
    win_id = pick_sum[ID_W-1:0];
  end

  // Grant bookkeeping: owner activity, beat accounting, forced release
  // and the pointer value used after the grant ends.
  always_comb begin
    in_grant    = (state_q == ST_GRANT);
    act_g       = req_act[grant_id_q];
    others_act  = |(req_act & ~(REQS'(1) << grant_id_q));
    access_beat = in_grant && (ramstate == RS_ACCESS) && act_g;
    beat_next   = {1'b0, beat_cnt_q} + (CNT_W+1)'(1);
    cap_hit     = (beat_next >= MAX_EXT);
    force_rel   = access_beat && cap_hit && others_act;
    ptr_sum     = {1'b0, grant_id_q} + (ID_W+1)'(1);
    if (ptr_sum >= REQS_EXT) begin
      ptr_sum = '0;
    end
    ptr_after = ptr_sum[ID_W-1:0];
  end

  // Next-state logic for the IDLE/GRANT controller.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_id_d = win_id;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // The count saturates so an uncontended owner can stream forever.
        if (access_beat) begin
          beat_cnt_d = cap_hit ? MAX_CNT : beat_next[CNT_W-1:0];
        end
        // The beat in a forced-release cycle still completes; only the
        // grant is dropped at the edge.
        if (!act_g || force_rel) begin
          state_d  = ST_IDLE;
          rr_ptr_d = ptr_after;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // RAM-side and requester-side outputs. All values are quiet while IDLE.
  // While granted, the owner's request is steered to the RAM. A write wins
  // when both enables are set.
  always_comb begin
    grant_valid = in_grant;
    grant_id    = '0;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    req_load    = '0;
    req_wait    = '1;
    if (in_grant) begin
      grant_id = grant_id_q;
      ramaddr  = req_addr[grant_id_q*ADDR_W +: ADDR_W];
      ramstore = req_store[grant_id_q*DATA_W +: DATA_W];
      if (req_wen[grant_id_q]) begin
        ramWEN = 1'b1;
      end else begin
        ramREN = req_ren[grant_id_q];
      end
      req_load = ramload;
      if (ramstate == RS_ACCESS) begin
        req_wait[grant_id_q] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: directed scenarios followed by random traffic.
// A reference model keeps track of the current owner, the next start
// index and the used beats. It predicts every cycle's outputs into a
// queue, and a monitor process compares the queue against the DUT on the
// falling edge.
module tb_ram_rr_arbiter;

  localparam int REQS      = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 4;
  localparam int ID_W      = 2;
  localparam int EXP_W     = 1 + ID_W + 1 + 1 + ADDR_W + DATA_W + DATA_W + REQS;

  logic                   CLK;
  logic                   nRST;
  logic [REQS-1:0]        req_ren;
  logic [REQS-1:0]        req_wen;
  logic [REQS*ADDR_W-1:0] req_addr;
  logic [REQS*DATA_W-1:0] req_store;
  logic [DATA_W-1:0]      req_load;
  logic [REQS-1:0]        req_wait;
  logic [ADDR_W-1:0]      ramaddr;
  logic [DATA_W-1:0]      ramstore;
  logic                   ramREN;
  logic                   ramWEN;
  logic [DATA_W-1:0]      ramload;
  logic [1:0]             ramstate;
  logic                   grant_valid;
  logic [ID_W-1:0]        grant_id;

  ram_rr_arbiter #(
    .REQS(REQS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store),
    .req_load(req_load), .req_wait(req_wait),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- stimulus state ----------------
  logic [REQS-1:0]   s_ren, s_wen;
  logic [ADDR_W-1:0] s_addr  [REQS];
  logic [DATA_W-1:0] s_store [REQS];
  logic [1:0]        s_ramstate;
  logic [DATA_W-1:0] s_ramload;
  logic              s_rst_n;
  bit                drop_after_beat;
  bit                rand_mode;

  // ---------------- reference model ----------------
  int m_owner = -1;   // -1: nobody holds the RAM
  int m_next  = 0;    // first index to consider at the next arbitration
  int m_beats = 0;    // ACCESS beats used by the current owner
  int m_beat_done_id = -1;

  logic [EXP_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic model_clock();
    int  g;
    bit  others;
    m_beat_done_id = -1;
    if (!nRST) begin
      m_owner = -1;
      m_next  = 0;
      m_beats = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < REQS; k++) begin
        int c;
        c = (m_next + k) % REQS;
        if (req_ren[c] || req_wen[c]) begin
          m_owner = c;
          m_beats = 0;
          break;
        end
      end
    end else begin
      g = m_owner;
      if (!(req_ren[g] || req_wen[g])) begin
        m_owner = -1;
        m_next  = (g + 1) % REQS;
      end else if (ramstate == 2'd2) begin
        m_beat_done_id = g;
        others = 1'b0;
        for (int j = 0; j < REQS; j++) begin
          if (j != g && (req_ren[j] || req_wen[j])) others = 1'b1;
        end
        if (m_beats + 1 >= MAX_BEATS && others) begin
          m_owner = -1;
          m_next  = (g + 1) % REQS;
        end else begin
          m_beats = (m_beats + 1 > MAX_BEATS) ? MAX_BEATS : m_beats + 1;
        end
      end
    end
  endtask

  function automatic logic [EXP_W-1:0] model_expect();
    logic              e_gv, e_ren, e_wen;
    logic [ID_W-1:0]   e_gid;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_store, e_load;
    logic [REQS-1:0]   e_wait;
    int g;
    e_gv = 1'b0; e_gid = '0; e_ren = 1'b0; e_wen = 1'b0;
    e_addr = '0; e_store = '0; e_load = '0; e_wait = '1;
    if (m_owner >= 0) begin
      g       = m_owner;
      e_gv    = 1'b1;
      e_gid   = g[ID_W-1:0];
      e_wen   = s_wen[g];
      e_ren   = s_wen[g] ? 1'b0 : s_ren[g];
      e_addr  = s_addr[g];
      e_store = s_store[g];
      e_load  = s_ramload;
      if (s_ramstate == 2'd2) e_wait[g] = 1'b0;
    end
    return {e_gv, e_gid, e_ren, e_wen, e_addr, e_store, e_load, e_wait};
  endfunction

  // ---------------- driver ----------------
  task automatic apply_stim();
    for (int i = 0; i < REQS; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]  = s_addr[i];
      req_store[i*DATA_W +: DATA_W] = s_store[i];
    end
    req_ren  = s_ren;
    req_wen  = s_wen;
    ramstate = s_ramstate;
    ramload  = s_ramload;
    nRST     = s_rst_n;
  endtask

  task automatic randomize_stim();
    int k;
    for (int i = 0; i < REQS; i++) begin
      if (s_ren[i] || s_wen[i]) begin
        if ((m_beat_done_id == i && $urandom_range(0, 1) == 0) || $urandom_range(0, 19) == 0) begin
          s_ren[i] = 1'b0;
          s_wen[i] = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, 3);
        s_ren[i]   = k[0];
        s_wen[i]   = k[1];
        s_addr[i]  = $urandom;
        s_store[i] = $urandom;
      end
    end
    s_ramstate = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'($urandom_range(0, 3));
    s_ramload  = $urandom;
    s_rst_n    = ($urandom_range(0, 99) != 0);
  endtask

  // One clock: advance the model at the edge, then drive the next inputs
  // and queue the outputs the model predicts for them.
  task automatic step();
    @(posedge CLK);
    model_clock();
    if (drop_after_beat && m_beat_done_id >= 0) begin
      s_ren[m_beat_done_id] = 1'b0;
      s_wen[m_beat_done_id] = 1'b0;
    end
    if (rand_mode) randomize_stim();
    #1;
    apply_stim();
    exp_q.push_back(model_expect());
  endtask

  task automatic dcheck(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EXP_W-1:0] exp_v, act_v;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {grant_valid, grant_id, ramREN, ramWEN, ramaddr, ramstore, req_load, req_wait};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, act_v, exp_v);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  int order[$];

  task automatic clear_reqs();
    s_ren = '0;
    s_wen = '0;
  endtask

  initial begin
    s_ren = '0; s_wen = '0; s_ramstate = 2'd0; s_ramload = '0; s_rst_n = 1'b0;
    for (int i = 0; i < REQS; i++) begin
      s_addr[i]  = '0;
      s_store[i] = '0;
    end
    drop_after_beat = 1'b0;
    rand_mode       = 1'b0;
    apply_stim();

    // Reset
    step(); step();
    s_rst_n = 1'b1;
    step(); #1;
    dcheck("reset_grant_valid", grant_valid, 0);
    dcheck("reset_wait", req_wait, 4'hF);
    dcheck("reset_enables", {ramREN, ramWEN}, 0);

    // Single read by requester 1 with BUSY,BUSY,ACCESS
    s_ren[1] = 1'b1; s_addr[1] = 32'h100; s_ramstate = 2'd1;
    step();
    step(); #1;
    dcheck("t1_grant", {grant_valid, grant_id}, {1'b1, 2'd1});
    dcheck("t1_ren_addr", {ramREN, ramaddr}, {1'b1, 32'h100});
    dcheck("t1_busy_wait", req_wait, 4'hF);
    step();
    s_ramstate = 2'd2; s_ramload = 32'hDEADBEEF;
    step(); #1;
    dcheck("t1_access_wait", req_wait, 4'b1101);
    dcheck("t1_load", req_load, 32'hDEADBEEF);
    clear_reqs(); s_ramstate = 2'd0;
    step(); step();

    // All four requesters at once after reset, one beat each
    s_rst_n = 1'b0; step();
    s_rst_n = 1'b1; step();
    s_ren = 4'hF; s_ramstate = 2'd2;
    for (int i = 0; i < REQS; i++) s_addr[i] = 32'h1000 + 32'(i * 16);
    drop_after_beat = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(); #1;
      if (grant_valid && (order.size() == 0 || order[order.size()-1] != int'(grant_id)))
        order.push_back(int'(grant_id));
    end
    drop_after_beat = 1'b0;
    dcheck("t2_grant_count", order.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) dcheck("t2_order", order[i], i);
    end
    clear_reqs();
    step();

    // Forced release after MAX_BEATS with requester 0 waiting
    s_ren[2] = 1'b1; s_ramstate = 2'd2;
    step();
    step();
    s_ren[0] = 1'b1;
    step(); step(); step(); #1;
    dcheck("t3_beat4_still_2", {grant_valid, grant_id}, {1'b1, 2'd2});
    step(); #1;
    dcheck("t3_idle_gap", grant_valid, 0);
    step(); #1;
    dcheck("t3_grant0", {grant_valid, grant_id}, {1'b1, 2'd0});
    clear_reqs();
    step(); step();

    // Requester 3 streams alone: no forced release
    s_ren[3] = 1'b1;
    step();
    for (int c = 0; c < 20; c++) begin
      step(); #1;
      dcheck("t4_hold_alone", {grant_valid, grant_id}, {1'b1, 2'd3});
    end
    s_ren[1] = 1'b1;
    step(); #1;
    dcheck("t4_saturated_beat", {grant_valid, grant_id}, {1'b1, 2'd3});
    step(); #1;
    dcheck("t4_release", grant_valid, 0);
    step(); #1;
    dcheck("t4_next_grant", {grant_valid, grant_id}, {1'b1, 2'd1});
    clear_reqs();
    step(); step();

    // Read+write together: write wins
    s_ren[0] = 1'b1; s_wen[0] = 1'b1; s_store[0] = 32'h55AA; s_addr[0] = 32'h200;
    s_ramstate = 2'd1;
    step();
    step(); #1;
    dcheck("t5_wen_ren", {ramWEN, ramREN}, 2'b10);
    dcheck("t5_store", ramstore, 32'h55AA);

    // ERROR holds the grant with all waits high, then reset mid-grant
    s_ramstate = 2'd3;
    step(); #1;
    dcheck("t6_error_wait", req_wait, 4'hF);
    dcheck("t6_error_grant", {grant_valid, grant_id}, {1'b1, 2'd0});
    s_rst_n = 1'b0;
    step();
    step(); #1;
    dcheck("t6_rst_grant", grant_valid, 0);
    dcheck("t6_rst_enables", {ramREN, ramWEN}, 0);
    dcheck("t6_rst_wait", req_wait, 4'hF);
    s_rst_n = 1'b1; clear_reqs(); s_ramstate = 2'd0;
    step();

    // Random traffic
    rand_mode = 1'b1;
    for (int c = 0; c < 1500; c++) step();
    rand_mode = 1'b0;
    clear_reqs(); s_rst_n = 1'b1;
    step(); step();
    @(negedge CLK); #1;
    dcheck("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
